// File: rtl/lb_pkg.sv
// Shared types and helpers for the N-row line-buffer window generator.
package lb_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  typedef logic [DATA_WIDTH_DEF-1:0] lane_t;

  localparam int BORDER_SUPPRESS = 0;
  localparam int BORDER_ZERO     = 1;

  // Zero or oversize line lengths fall back to the full RAM depth.
  function automatic int clamp_len(input int len, input int max);
    return (len == 0 || len > max) ? max : len;
  endfunction
endpackage

// File: rtl/lb_row_ram.sv
// One line of pixel history: write on the clock, read combinationally so a
// write cycle still returns the previous contents (read-before-write).
module lb_row_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_LEN    = 100
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MAX_LEN];

  assign rdata = mem[addr];

  always_ff @(posedge clk)
    if (en) mem[addr] <= wdata;
endmodule

// File: rtl/lb_window_nrow.sv
// Streaming ROWS-tall vertical window: cascaded line RAMs share one column
// counter; all lanes are registered together one cycle after the pixel.
module lb_window_nrow import lb_pkg::*; #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 7,
  parameter int MAX_LEN     = 100,
  parameter int ROWS        = 3,
  parameter int BORDER_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH:0]        cfg_line_len,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]      out_col,
  output logic                       out_last_col,
  output logic                       err_short
);
  localparam int CNT_W = $clog2(ROWS);
  localparam int LW    = ADDR_WIDTH + 1;
  localparam bit SUPPRESS = (BORDER_MODE == BORDER_SUPPRESS);

  logic [ADDR_WIDTH-1:0] col, col_eff;
  logic [LW-1:0]         line_len, len_eff;
  logic [CNT_W-1:0]      row_cnt, rc_eff;
  logic                  sof, wrap, full, short_err;
  logic [ROWS-1:0]       fill;
  logic [ROWS-1:0][DATA_WIDTH-1:0] lane, lane_m;

  assign sof = in_valid & in_sof;

  // Frame start overrides the running counters for this very pixel.
  always_comb begin
    col_eff = col;
    rc_eff  = row_cnt;
    len_eff = line_len;
    if (sof) begin
      col_eff = '0;
      rc_eff  = '0;
      len_eff = LW'(clamp_len(int'(cfg_line_len), MAX_LEN));
    end
  end

  assign wrap = ({1'b0, col_eff} == len_eff - LW'(1));
  assign full = (int'(rc_eff) == ROWS - 1);
  // A sof landing where the line would wrap anyway is a clean frame boundary.
  assign short_err = sof && (col != '0) && ({1'b0, col} != line_len - LW'(1));

  for (genvar k = 0; k < ROWS - 1; k++) begin : g_ram
    logic [DATA_WIDTH-1:0] wd;
    if (k == ROWS - 2) begin : g_top
      assign wd = in_data;
    end else begin : g_mid
      assign wd = lane[k+1];
    end
    lb_row_ram #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MAX_LEN(MAX_LEN)
    ) u_ram (
      .clk(clk), .en(in_valid), .addr(col_eff), .wdata(wd), .rdata(lane[k])
    );
  end
  assign lane[ROWS-1] = in_data;

  always_comb begin
    fill   = '0;
    lane_m = '0;
    for (int k = 0; k < ROWS; k++) begin
      fill[k]   = (int'(rc_eff) >= ROWS - 1 - k);
      lane_m[k] = fill[k] ? lane[k] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col          <= '0;
      row_cnt      <= '0;
      line_len     <= LW'(MAX_LEN);
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_col      <= '0;
      out_last_col <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      out_valid <= in_valid && (!SUPPRESS || full);
      err_short <= short_err;
      if (in_valid) begin
        line_len     <= len_eff;
        out_data     <= lane_m;
        out_col      <= col_eff;
        out_last_col <= wrap;
        if (wrap) begin
          col     <= '0;
          row_cnt <= full ? rc_eff : rc_eff + CNT_W'(1);
        end else begin
          col     <= col_eff + ADDR_WIDTH'(1);
          row_cnt <= rc_eff;
        end
      end
    end
  end
endmodule

// File: tb/tb_lb_window_nrow.sv
// Scoreboard bench: three DUT flavours share one pixel stream; a frame-store
// model predicts every output cycle and scenario tasks add targeted checks.
module tb_lb_window_nrow;
  typedef struct {
    logic        v;
    logic [79:0] d;
    logic [6:0]  c;
    logic        l;
    logic        e;
  } rec_t;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0]  cfg_line_len = 8'd4;
  logic [15:0] in_data = '0;
  logic        ov0, ov1, ov2, ol0, ol1, ol2, oe0, oe1, oe2;
  logic [47:0] od0, od1;
  logic [79:0] od2;
  logic [6:0]  oc0, oc1, oc2;

  int errors = 0, checks = 0;
  rec_t q0[$], q1[$], q2[$];
  int mcol[3], mrow[3], mlen[3];
  int rows_of[3] = '{3, 3, 5};
  bit bm_of[3]   = '{1'b0, 1'b1, 1'b0};
  logic [15:0] pix[3][8][100];

  always #5 clk = ~clk;

  lb_window_nrow #(.ROWS(3), .BORDER_MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .cfg_line_len(cfg_line_len), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(in_data), .out_valid(ov0), .out_data(od0),
    .out_col(oc0), .out_last_col(ol0), .err_short(oe0));
  lb_window_nrow #(.ROWS(3), .BORDER_MODE(1)) u3b (
    .clk(clk), .rst_n(rst_n), .cfg_line_len(cfg_line_len), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(in_data), .out_valid(ov1), .out_data(od1),
    .out_col(oc1), .out_last_col(ol1), .err_short(oe1));
  lb_window_nrow #(.ROWS(5), .BORDER_MODE(0)) u5 (
    .clk(clk), .rst_n(rst_n), .cfg_line_len(cfg_line_len), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(in_data), .out_valid(ov2), .out_data(od2),
    .out_col(oc2), .out_last_col(ol2), .err_short(oe2));

  function automatic rec_t get_out(input int i);
    rec_t r;
    r = '{default: '0};
    case (i)
      0: begin r.v = ov0; r.d = {32'd0, od0}; r.c = oc0; r.l = ol0; r.e = oe0; end
      1: begin r.v = ov1; r.d = {32'd0, od1}; r.c = oc1; r.l = ol1; r.e = oe1; end
      default: begin r.v = ov2; r.d = od2; r.c = oc2; r.l = ol2; r.e = oe2; end
    endcase
    return r;
  endfunction

  // Frame-store model: keeps every line of the frame by absolute row number.
  task automatic model_step(input int i, output rec_t r);
    int R, c, len, d;
    R = rows_of[i];
    r = '{default: '0};
    if (in_valid) begin
      if (in_sof) begin
        r.e = (mcol[i] != 0) && (mcol[i] != mlen[i] - 1);
        mlen[i] = (cfg_line_len == 0 || cfg_line_len > 100) ? 100 : int'(cfg_line_len);
        mcol[i] = 0;
        mrow[i] = 0;
      end
      c   = mcol[i];
      len = mlen[i];
      r.v = bm_of[i] || (mrow[i] >= R - 1);
      for (int k = 0; k < R; k++) begin
        d = R - 1 - k;
        if (d == 0) r.d[k*16 +: 16] = in_data;
        else if (mrow[i] >= d) r.d[k*16 +: 16] = pix[i][(mrow[i] - d) % 8][c];
      end
      r.c = 7'(c);
      r.l = (c == len - 1);
      pix[i][mrow[i] % 8][c] = in_data;
      if (c == len - 1) begin mcol[i] = 0; mrow[i]++; end
      else mcol[i] = c + 1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin mcol[i] = 0; mrow[i] = 0; mlen[i] = 100; end
  endtask

  task automatic cyc(input bit v, input bit s, input logic [15:0] dat);
    rec_t r;
    @(negedge clk);
    in_valid = v; in_sof = s; in_data = dat;
    model_step(0, r); q0.push_back(r);
    model_step(1, r); q1.push_back(r);
    model_step(2, r); q2.push_back(r);
  endtask

  task automatic monitor();
    rec_t e, a;
    bit got;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) begin
        got = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (got) begin
          a = get_out(i);
          checks++;
          if (a.v !== e.v) begin errors++; $display("FAIL sb_valid inst=%0d got=%b exp=%b t=%0t", i, a.v, e.v, $time); end
          checks++;
          if (a.e !== e.e) begin errors++; $display("FAIL sb_err_short inst=%0d got=%b exp=%b t=%0t", i, a.e, e.e, $time); end
          if (e.v) begin
            checks++;
            if (a.d !== e.d || a.c !== e.c || a.l !== e.l) begin
              errors++;
              $display("FAIL sb_data inst=%0d got=%h/%0d/%b exp=%h/%0d/%b t=%0t", i, a.d, a.c, a.l, e.d, e.c, e.l, $time);
            end
          end
        end
      end
    end
  endtask

  task automatic chk_zero(input string name);
    rec_t a;
    for (int i = 0; i < 3; i++) begin
      a = get_out(i);
      checks++;
      if (a.v !== 1'b0 || a.d !== '0 || a.c !== '0 || a.l !== 1'b0 || a.e !== 1'b0) begin
        errors++;
        $display("FAIL %s inst=%0d got v=%b d=%h c=%0d l=%b e=%b exp all 0", name, i, a.v, a.d, a.c, a.l, a.e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
    repeat (2) @(posedge clk);
    #2 chk_zero("reset_state");
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; model_reset();
  endtask

  task automatic test_basic();
    cfg_line_len = 8'd4;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, i == 0, 16'(i));
      @(posedge clk); #2;
      checks++;
      case (i)
        0: if (ov1 !== 1'b1 || od1 !== 48'd0) begin errors++; $display("FAIL bm1_px0 got %b/%h exp 1/0", ov1, od1); end
        4: if (od1 !== {16'd4, 16'd0, 16'd0}) begin errors++; $display("FAIL bm1_px4 got %h", od1); end
        7: if (ov0 !== 1'b0) begin errors++; $display("FAIL bm0_px7_valid got %b exp 0", ov0); end
        8: if (ov0 !== 1'b1 || od0 !== {16'd8, 16'd4, 16'd0} || od1 !== {16'd8, 16'd4, 16'd0})
             begin errors++; $display("FAIL px8_window got %b/%h/%h exp 1/{8,4,0}", ov0, od0, od1); end
        9: if (od0 !== {16'd9, 16'd5, 16'd1}) begin errors++; $display("FAIL px9_window got %h exp {9,5,1}", od0); end
        11: if (ol0 !== 1'b1 || oc0 !== 7'd3) begin errors++; $display("FAIL px11_last got %b/%0d exp 1/3", ol0, oc0); end
        default: if (ov1 !== 1'b1) begin errors++; $display("FAIL bm1_valid px%0d got %b exp 1", i, ov1); end
      endcase
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_gaps();
    int g;
    for (int i = 0; i < 12; i++) begin
      g = $urandom_range(0, 2);
      repeat (g) cyc(1'b0, 1'b0, '0);
      cyc(1'b1, i == 0, 16'(100 + i));
      @(posedge clk); #2;
      checks++;
      if (ov1 !== 1'b1) begin errors++; $display("FAIL gap_latency px%0d got %b exp 1", i, ov1); end
      if (i >= 8) begin
        checks++;
        if (od0 !== {16'(100 + i), 16'(96 + i), 16'(92 + i)})
          begin errors++; $display("FAIL gap_window px%0d got %h", i, od0); end
      end
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_short();
    cfg_line_len = 8'd4;
    cyc(1'b1, 1'b1, 16'd200);
    @(posedge clk); #2;
    checks++;
    if (oe0 !== 1'b0) begin errors++; $display("FAIL sof_at_col0 err got %b exp 0", oe0); end
    cyc(1'b1, 1'b0, 16'd201);
    cyc(1'b1, 1'b1, 16'd210);
    @(posedge clk); #2;
    checks++;
    if (oe0 !== 1'b1 || oc1 !== 7'd0) begin errors++; $display("FAIL short_line err/col got %b/%0d exp 1/0", oe0, oc1); end
    for (int j = 1; j < 12; j++) begin
      cyc(1'b1, 1'b0, 16'(210 + j));
      @(posedge clk); #2;
      checks++;
      if (oe0 !== 1'b0 || ov0 !== (j >= 8)) begin errors++; $display("FAIL short_refill px%0d got v=%b e=%b", j, ov0, oe0); end
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_len();
    cfg_line_len = 8'd0;
    for (int i = 0; i < 200; i++) begin
      if (i == 50) cfg_line_len = 8'd4;
      cyc(1'b1, i == 0, 16'(i));
      if (i == 98 || i == 99 || i == 100) begin
        @(posedge clk); #2;
        checks++;
        if (oc1 !== 7'(i % 100) || ol1 !== (i == 99))
          begin errors++; $display("FAIL len0_wrap px%0d got col=%0d last=%b", i, oc1, ol1); end
      end
    end
    cfg_line_len = 8'd200;
    for (int i = 0; i < 101; i++) begin
      cyc(1'b1, i == 0, 16'(1000 + i));
      if (i == 0 || i == 99 || i == 100) begin
        @(posedge clk); #2;
        checks++;
        if (oc1 !== 7'(i % 100) || ol1 !== (i == 99) || oe1 !== 1'b0)
          begin errors++; $display("FAIL len200_wrap px%0d got col=%0d last=%b err=%b", i, oc1, ol1, oe1); end
      end
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    cfg_line_len = 8'd3;
    cyc(1'b1, 1'b1, 16'd40);
    cyc(1'b1, 1'b0, 16'd41);
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b1; in_data = 16'd77;
    @(posedge clk); #2 chk_zero("mid_reset");
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; model_reset();
    cyc(1'b1, 1'b0, 16'd55);
    @(posedge clk); #2;
    checks++;
    if (ov1 !== 1'b1 || oc1 !== 7'd0) begin errors++; $display("FAIL post_reset_col got %b/%0d exp 1/0", ov1, oc1); end
    for (int j = 0; j < 15; j++) begin
      cyc(1'b1, j == 0, 16'(300 + j));
      if (j == 11 || j == 12) begin
        @(posedge clk); #2;
        checks++;
        if (ov2 !== (j == 12)) begin errors++; $display("FAIL rows5_first px%0d got %b", j, ov2); end
      end
      if (j == 12) begin
        checks++;
        if (od2 !== {16'd312, 16'd309, 16'd306, 16'd303, 16'd300})
          begin errors++; $display("FAIL rows5_window got %h", od2); end
      end
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  initial begin
    model_reset();
    fork monitor(); join_none
    test_reset();
    test_basic();
    test_gaps();
    test_short();
    test_len();
    test_reset_mid();
    @(posedge clk); #3;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0)
      begin errors++; $display("FAIL sb_drain got %0d pending exp 0", q0.size() + q1.size() + q2.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
